// File: rtl/karatsuba_pkg.sv
// Shared types and width helpers for the Karatsuba term generator.
package karatsuba_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_K1  = 3'd1,
        ST_MUL_K2  = 3'd2,
        ST_MUL_K3  = 3'd3,
        ST_COMBINE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    function automatic int unsigned half_w(input int unsigned n);
        return n / 2;
    endfunction

    function automatic int unsigned mul_w(input int unsigned n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/karatsuba_term_gen_if.sv
// Operand-in / terms-out handshake bundle for the Karatsuba term generator.
interface karatsuba_term_gen_if #(
    parameter int unsigned N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] g1;
    logic [2*N-1:0] g2;
    logic [2*N-1:0] g3;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, g1, g2, g3
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, g1, g2, g3
    );
endinterface

// File: rtl/kara_shift_add_mul.sv
// Radix-2 shift-add multiplier, one iteration per cycle; start is held high
// for the M cycles of a product and prod_c is the finished product when done_c.
module kara_shift_add_mul #(
    parameter int unsigned M = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   x,
    input  logic [M-1:0]   y,
    output logic           done_c,
    output logic [2*M-1:0] prod_c
);
    localparam int unsigned PW = 2 * M;
    localparam int unsigned CW = $clog2(M);

    logic [CW-1:0] cnt;
    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [M-1:0]  mplier;
    logic          first;
    logic [PW-1:0] mcand_cur;
    logic [M-1:0]  mplier_cur;
    logic [PW-1:0] addend;
    logic [PW-1:0] acc_nxt;

    // First iteration takes operands straight from the ports so no load cycle is spent.
    always_comb begin
        first      = (cnt == '0);
        mcand_cur  = first ? PW'(x) : mcand;
        mplier_cur = first ? y : mplier;
        addend     = mplier_cur[0] ? mcand_cur : '0;
        acc_nxt    = (first ? '0 : acc) + addend;
    end

    assign prod_c = acc_nxt;
    assign done_c = start && (cnt == CW'(M - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            acc    <= acc_nxt;
            mcand  <= mcand_cur << 1;
            mplier <= mplier_cur >> 1;
            cnt    <= done_c ? '0 : cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end
endmodule

// File: rtl/karatsuba_term_gen.sv
// Sequential Karatsuba front end: forms k1, k2, k3 on one shared multiplier
// and emits the aligned terms g1, g2, g3 for the downstream 3-operand adder.
module karatsuba_term_gen
    import karatsuba_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    karatsuba_term_gen_if.slave  bus,
    output logic                 busy
);
    localparam int unsigned H  = half_w(N);
    localparam int unsigned M  = mul_w(N);
    localparam int unsigned PW = 2 * M;
    localparam int unsigned GW = 2 * N;

    state_t        state;
    state_t        state_nxt;
    logic [H-1:0]  ah, al, bh, bl;
    logic [M-1:0]  sa, sb;
    logic [N-1:0]  k1, k2;
    logic [PW-1:0] k3;
    logic [PW-1:0] mid_c;
    logic          mul_start;
    logic [M-1:0]  mul_x, mul_y;
    logic          mul_done_c;
    logic [PW-1:0] mul_prod_c;

    kara_shift_add_mul #(.M(M)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .x      (mul_x),
        .y      (mul_y),
        .done_c (mul_done_c),
        .prod_c (mul_prod_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and multiplier operand steering.
    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        mul_x     = '0;
        mul_y     = '0;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nxt = ST_MUL_K1;
            ST_MUL_K1: begin
                mul_start = 1'b1;
                mul_x     = M'(ah);
                mul_y     = M'(bh);
                if (mul_done_c) state_nxt = ST_MUL_K2;
            end
            ST_MUL_K2: begin
                mul_start = 1'b1;
                mul_x     = M'(al);
                mul_y     = M'(bl);
                if (mul_done_c) state_nxt = ST_MUL_K3;
            end
            ST_MUL_K3: begin
                mul_start = 1'b1;
                mul_x     = sa;
                mul_y     = sb;
                if (mul_done_c) state_nxt = ST_COMBINE;
            end
            ST_COMBINE: state_nxt = ST_DONE;
            ST_DONE:    if (bus.out_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // k3 >= k1 + k2 always, so the middle term never underflows.
    assign mid_c = k3 - PW'(k1) - PW'(k2);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            bus.in_ready  <= (state_nxt == ST_IDLE);
            bus.out_valid <= (state_nxt == ST_DONE);
            busy          <= (state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ah     <= '0;
            al     <= '0;
            bh     <= '0;
            bl     <= '0;
            sa     <= '0;
            sb     <= '0;
            k1     <= '0;
            k2     <= '0;
            k3     <= '0;
            bus.g1 <= '0;
            bus.g2 <= '0;
            bus.g3 <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    ah <= bus.a[N-1:H];
                    al <= bus.a[H-1:0];
                    bh <= bus.b[N-1:H];
                    bl <= bus.b[H-1:0];
                    sa <= M'(bus.a[N-1:H]) + M'(bus.a[H-1:0]);
                    sb <= M'(bus.b[N-1:H]) + M'(bus.b[H-1:0]);
                end
                ST_MUL_K1: if (mul_done_c) k1 <= N'(mul_prod_c);
                ST_MUL_K2: if (mul_done_c) k2 <= N'(mul_prod_c);
                ST_MUL_K3: if (mul_done_c) k3 <= mul_prod_c;
                ST_COMBINE: begin
                    bus.g1 <= GW'(k1) << N;
                    bus.g2 <= GW'(mid_c) << H;
                    bus.g3 <= GW'(k2);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_term_gen.sv
// Self-checking bench for karatsuba_term_gen against a plain-arithmetic model.
module tb_karatsuba_term_gen;
    localparam int unsigned N   = 32;
    localparam int unsigned M   = N / 2 + 1;
    localparam int          LAT = 3 * M + 1;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    karatsuba_term_gen_if #(.N(N)) bus ();

    karatsuba_term_gen #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: split into halves and form the three Karatsuba terms arithmetically.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] e1, output logic [63:0] e2,
                                  output logic [63:0] e3);
        logic [63:0] ah, al, bh, bl, k1, k2, k3;
        ah = 64'(a >> 16);
        al = 64'(a & 32'h0000FFFF);
        bh = 64'(b >> 16);
        bl = 64'(b & 32'h0000FFFF);
        k1 = ah * bh;
        k2 = al * bl;
        k3 = (ah + al) * (bh + bl);
        e1 = k1 << 32;
        e2 = (k3 - k1 - k2) << 16;
        e3 = k2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     bus.in_ready, bus.out_valid, busy);
        end
        checks++;
        if (bus.g1 !== 64'd0 || bus.g2 !== 64'd0 || bus.g3 !== 64'd0) begin
            errors++;
            $display("FAIL reset_terms: g1=%h g2=%h g3=%h want 0", bus.g1, bus.g2, bus.g3);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [63:0] ts [3];
        logic [63:0] e1, e2, e3, sum;
        int lat;
        ta = '{32'h12001300, 32'hFFFFFFFF, 32'h00000000};
        tb = '{32'h14001002, 32'hFFFFFFFF, 32'hDEADBEEF};
        ts = '{64'h0168029C25302600, 64'hFFFFFFFE00000001, 64'h0};
        for (int i = 0; i < 3; i++) begin
            model(ta[i], tb[i], e1, e2, e3);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_ready: in_ready=%b want 1", i, bus.in_ready);
            end
            start_op(ta[i], tb[i]);
            checks++;
            if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_busy: busy=%b in_ready=%b want 1 0", i, busy, bus.in_ready);
            end
            wait_valid(lat);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT);
            end
            checks++;
            if (bus.g1 !== e1 || bus.g2 !== e2 || bus.g3 !== e3) begin
                errors++;
                $display("FAIL dir%0d_terms: g1=%h g2=%h g3=%h want %h %h %h",
                         i, bus.g1, bus.g2, bus.g3, e1, e2, e3);
            end
            sum = bus.g1 + bus.g2 + bus.g3;
            checks++;
            if (sum !== ts[i] || sum !== 64'(ta[i]) * 64'(tb[i])) begin
                errors++;
                $display("FAIL dir%0d_sum: got %h want %h", i, sum, ts[i]);
            end
            release_out();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_release: out_valid=%b in_ready=%b want 0 1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [63:0] e1, e2, e3;
        int lat;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a = a | 32'hFFFF0000;
            if (i % 4 == 2) b = b | 32'h0000FFFF;
            model(a, b, e1, e2, e3);
            start_op(a, b);
            wait_valid(lat);
            repeat ($urandom_range(0, 4)) tick();
            checks++;
            if (lat !== LAT || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_latency: got %0d valid=%b want %0d 1", i, lat, bus.out_valid, LAT);
            end
            checks++;
            if (bus.g1 + bus.g2 + bus.g3 !== 64'(a) * 64'(b) ||
                bus.g1 !== e1 || bus.g2 !== e2 || bus.g3 !== e3) begin
                errors++;
                $display("FAIL rnd%0d_terms: a=%h b=%h g1=%h g2=%h g3=%h want %h %h %h",
                         i, a, b, bus.g1, bus.g2, bus.g3, e1, e2, e3);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        logic [63:0] e1, e2, e3;
        int lat;
        int bad;
        a = $urandom;
        b = $urandom;
        model(a, b, e1, e2, e3);
        start_op(a, b);
        wait_valid(lat);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.g1 !== e1 || bus.g2 !== e2 || bus.g3 !== e3) bad++;
        end
        checks++;
        if (lat !== LAT || bad != 0) begin
            errors++;
            $display("FAIL hold_stable: lat=%0d unstable_cycles=%0d want %0d 0", lat, bad, LAT);
        end
        release_out();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     bus.out_valid, bus.in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [63:0] e1, e2, e3;
        int lat;
        start_op(32'h00010002, 32'h00030004);
        wait_valid(lat);
        a = $urandom;
        b = $urandom;
        model(a, b, e1, e2, e3);
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_edge: out_valid=%b busy=%b in_ready=%b want 0 0 1",
                     bus.out_valid, busy, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b want 1", busy);
        end
        wait_valid(lat);
        checks++;
        if (lat !== LAT || bus.g1 !== e1 || bus.g2 !== e2 || bus.g3 !== e3) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d g1=%h g2=%h g3=%h want %0d %h %h %h",
                     lat, bus.g1, bus.g2, bus.g3, LAT, e1, e2, e3);
        end
        release_out();
    endtask

    task automatic test_ignore_busy();
        logic [31:0] a, b;
        logic [63:0] e1, e2, e3;
        int lat;
        int bad;
        a = 32'hA5A51234;
        b = 32'h0F0FC3C3;
        model(a, b, e1, e2, e3);
        start_op(a, b);
        lat = -1;
        bad = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.in_ready !== 1'b0) bad++;
            if (k >= M + 2 && k <= M + 6) begin
                bus.in_valid = 1'b1;
                bus.a        = $urandom;
                bus.b        = $urandom;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad != 0 || lat !== LAT) begin
            errors++;
            $display("FAIL ignore_ready: ready_high_cycles=%0d lat=%0d want 0 %0d", bad, lat, LAT);
        end
        checks++;
        if (bus.g1 !== e1 || bus.g2 !== e2 || bus.g3 !== e3) begin
            errors++;
            $display("FAIL ignore_result: g1=%h g2=%h g3=%h want %h %h %h",
                     bus.g1, bus.g2, bus.g3, e1, e2, e3);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        logic [63:0] e1, e2, e3;
        int lat;
        int seen;
        start_op($urandom, $urandom);
        repeat (2 * M + 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ctrl: busy=%b out_valid=%b in_ready=%b want 0 0 1",
                     busy, bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.g1 !== 64'd0 || bus.g2 !== 64'd0 || bus.g3 !== 64'd0) begin
            errors++;
            $display("FAIL rstmid_terms: g1=%h g2=%h g3=%h want 0", bus.g1, bus.g2, bus.g3);
        end
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_no_valid: out_valid cycles=%0d want 0", seen);
        end
        a = $urandom;
        b = $urandom;
        model(a, b, e1, e2, e3);
        start_op(a, b);
        wait_valid(lat);
        checks++;
        if (lat !== LAT || bus.g1 !== e1 || bus.g2 !== e2 || bus.g3 !== e3) begin
            errors++;
            $display("FAIL rstmid_fresh: lat=%0d g1=%h g2=%h g3=%h want %0d %h %h %h",
                     lat, bus.g1, bus.g2, bus.g3, LAT, e1, e2, e3);
        end
        release_out();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
